aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_key_expander.sv | 174 +++++++++++++++++
 tb/tb_aes_key_expander.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// AES key schedule generator: expands a 128/192/256-bit cipher key into round-key
// words one per cycle using a shared external S-box, then serves words on request.
module aes_key_expander (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  input  logic         req,
  input  logic [3:0]   req_round,
  input  logic [1:0]   req_col,
  input  logic         dec,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         ready,
  output logic         word_valid,
  output logic [31:0]  word_out,
  output logic         req_err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 60;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned KMOD_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic [KMOD_W-1:0]   kmod_q, kmod_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [WORD_W-1:0]   w_q [NWORDS];
  logic [WORD_W-1:0]   w_d [NWORDS];
  logic                ready_q, ready_d;
  logic                word_valid_q, word_valid_d;
  logic [WORD_W-1:0]   word_out_q, word_out_d;
  logic                req_err_q, req_err_d;

  logic [3:0]          nk, nr, nk_new;
  logic [IDX_W-1:0]    last_idx;
  logic                start_ok;
  logic [WORD_W-1:0]   prev_w, rot_w, temp_w;
  logic [3:0]          r_eff;

  // Words per key for a given mode encoding (11 never reaches here as a latched mode)
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    unique case (m)
      2'b01:   nk_of = 4'd6;
      2'b10:   nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    nk       = nk_of(mode_q);
    nr       = nk + 4'd6;
    // Last word index is 4*Nr+3
    last_idx = {nr, 2'b11};
    nk_new   = nk_of(mode);
    start_ok = start && (mode != 2'b11) && (state_q != S_EXPAND);
  end

  // Next-state, schedule datapath and request response
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    i_d          = i_q;
    kmod_d       = kmod_q;
    rcon_d       = rcon_q;
    w_d          = w_q;
    ready_d      = ready_q;
    word_valid_d = 1'b0;
    word_out_d   = '0;
    req_err_d    = 1'b0;
    sbox_in      = '0;
    prev_w       = '0;
    rot_w        = '0;
    temp_w       = '0;
    r_eff        = '0;

    if (state_q == S_EXPAND) begin
      prev_w = w_q[i_q - IDX_W'(1)];
      rot_w  = {prev_w[23:0], prev_w[31:24]};
      if (kmod_q == '0) begin
        sbox_in = rot_w;
        temp_w  = sbox_out ^ {rcon_q, 24'h000000};
        rcon_d  = xtime(rcon_q);
      end else if ((nk == 4'd8) && (kmod_q == KMOD_W'(4))) begin
        sbox_in = prev_w;
        temp_w  = sbox_out;
      end else begin
        sbox_in = prev_w;
        temp_w  = prev_w;
      end
      w_d[i_q] = w_q[i_q - IDX_W'(nk)] ^ temp_w;
      kmod_d   = (kmod_q == KMOD_W'(nk - 4'd1)) ? '0 : kmod_q + KMOD_W'(1);
      if (i_q == last_idx) begin
        state_d = S_READY;
        ready_d = 1'b1;
      end else begin
        i_d = i_q + IDX_W'(1);
      end
    end

    // A start accepted in READY swallows any request of the same cycle
    if ((state_q == S_READY) && req && !start_ok) begin
      if (req_round <= nr) begin
        r_eff        = dec ? (nr - req_round) : req_round;
        word_out_d   = w_q[{r_eff, req_col}];
        word_valid_d = 1'b1;
      end else begin
        req_err_d = 1'b1;
      end
    end

    if (start_ok) begin
      mode_d = mode;
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk_new)) begin
          w_d[j] = key_in[255 - 32*j -: 32];
        end
      end
      i_d     = IDX_W'(nk_new);
      kmod_d  = '0;
      rcon_d  = 8'h01;
      ready_d = 1'b0;
      state_d = S_EXPAND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      i_q          <= '0;
      kmod_q       <= '0;
      rcon_q       <= 8'h01;
      ready_q      <= 1'b0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      i_q          <= i_d;
      kmod_q       <= kmod_d;
      rcon_q       <= rcon_d;
      ready_q      <= ready_d;
      word_valid_q <= word_valid_d;
      word_out_q   <= word_out_d;
      req_err_q    <= req_err_d;
    end
  end

  // Schedule storage is not cleared by reset
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign ready      = ready_q;
  assign word_valid = word_valid_q;
  assign word_out   = word_out_q;
  assign req_err    = req_err_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed + randomized bench for aes_key_expander against a FIPS-197 style
// key-expansion model and a generated S-box.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         req;
  logic [3:0]   req_round;
  logic [1:0]   req_col;
  logic         dec;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         ready;
  logic         word_valid;
  logic [31:0]  word_out;
  logic         req_err;

  int total = 0;
  int bad   = 0;
  int cur_nr;
  logic [7:0]  sb [256];
  logic [31:0] ref_w [60];

  aes_key_expander dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .key_in     (key_in),
    .req        (req),
    .req_round  (req_round),
    .req_col    (req_col),
    .dec        (dec),
    .sbox_in    (sbox_in),
    .sbox_out   (sbox_out),
    .ready      (ready),
    .word_valid (word_valid),
    .word_out   (word_out),
    .req_err    (req_err)
  );

  always #5 clk = ~clk;

  assign sbox_out = {sb[sbox_in[31:24]], sb[sbox_in[23:16]], sb[sbox_in[15:8]], sb[sbox_in[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic expand_ref(input logic [1:0] m, input logic [255:0] key);
    int nk = 4 + 2 * int'(m);
    int t  = 4 * (nk + 7);
    logic [7:0]  rc = 8'h01;
    logic [31:0] tmp;
    for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < t; i++) begin
      tmp = ref_w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      ref_w[i] = ref_w[i-nk] ^ tmp;
    end
    cur_nr = nk + 6;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start with a same-cycle request (must be dropped), then wait for ready
  task automatic run_start(input logic [1:0] m, input logic [255:0] key, input int exp_cycles, input string tag);
    int cycles = 0;
    expand_ref(m, key);
    start = 1'b1; mode = m; key_in = key;
    req = 1'b1; req_round = 4'd0; req_col = 2'd0; dec = 1'b0;
    step();
    start = 1'b0; req = 1'b0;
    chk({tag, "_start_valid"}, {31'b0, word_valid}, 32'd0);
    chk({tag, "_start_ready"}, {31'b0, ready}, 32'd0);
    while (!ready && cycles < 200) begin
      step();
      cycles++;
    end
    chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
  endtask

  task automatic req_chk(input logic [3:0] r, input logic [1:0] c, input logic d, input string tag);
    int idx;
    req = 1'b1; req_round = r; req_col = c; dec = d;
    step();
    req = 1'b0;
    if (int'(r) <= cur_nr) begin
      idx = 4 * (d ? cur_nr - int'(r) : int'(r)) + int'(c);
      chk({tag, "_valid"}, {31'b0, word_valid}, 32'd1);
      chk({tag, "_word"}, word_out, ref_w[idx]);
      chk({tag, "_err"}, {31'b0, req_err}, 32'd0);
    end else begin
      chk({tag, "_oor_valid"}, {31'b0, word_valid}, 32'd0);
      chk({tag, "_oor_word"}, word_out, 32'd0);
      chk({tag, "_oor_err"}, {31'b0, req_err}, 32'd1);
      step();
      chk({tag, "_oor_err_clr"}, {31'b0, req_err}, 32'd0);
    end
  endtask

  initial begin
    logic [255:0] k128, k192, k256, rk;
    logic [1:0]   rm;
    int           cyc;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    build_sbox();
    reset = 1'b1; start = 1'b0; mode = 2'b00; key_in = '0;
    req = 1'b0; req_round = '0; req_col = '0; dec = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_err", {31'b0, req_err}, 32'd0);
    chk("rst_word", word_out, 32'd0);
    chk("rst_sbox", sbox_in, 32'd0);

    // AES-128 with a request and a foreign start injected mid-expansion
    expand_ref(2'b00, k128);
    start = 1'b1; mode = 2'b00; key_in = k128;
    step();
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 200) begin
      if (cyc == 5) begin req = 1'b1; req_round = 4'd1; end
      if (cyc == 10) begin start = 1'b1; mode = 2'b01; key_in = k192; end
      step();
      cyc++;
      start = 1'b0; req = 1'b0;
      if (cyc == 6) begin
        chk("exp_req_valid", {31'b0, word_valid}, 32'd0);
        chk("exp_req_err", {31'b0, req_err}, 32'd0);
      end
    end
    chk("a128_cycles", 32'(cyc), 32'd40);
    chk("a128_ref_w4", ref_w[4], 32'ha0fafe17);
    chk("a128_ref_w43", ref_w[43], 32'hb6630ca6);
    req_chk(4'd1, 2'd0, 1'b0, "a128_r1c0");
    chk("a128_r1c0_const", word_out, 32'ha0fafe17);
    req_chk(4'd10, 2'd3, 1'b0, "a128_r10c3");
    chk("a128_r10c3_const", word_out, 32'hb6630ca6);
    req_chk(4'd11, 2'd0, 1'b0, "a128_r11");

    // Back-to-back decrypt-order requests for round 0
    req = 1'b1; dec = 1'b1; req_round = 4'd0; req_col = 2'd0;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("b2b_valid", {31'b0, word_valid}, 32'd1);
      chk("b2b_word", word_out, ref_w[40 + c]);
      if (c < 3) req_col = 2'(c + 1);
      else req = 1'b0;
      step();
    end
    chk("b2b_end_valid", {31'b0, word_valid}, 32'd0);
    chk("b2b_end_word", word_out, 32'd0);

    run_start(2'b01, k192, 46, "a192");
    chk("a192_ref_w6", ref_w[6], 32'hfe0c91f7);
    req_chk(4'd1, 2'd2, 1'b0, "a192_r1c2");
    chk("a192_r1c2_const", word_out, 32'hfe0c91f7);
    req_chk(4'd12, 2'd3, 1'b1, "a192_dec");
    req_chk(4'd13, 2'd1, 1'b0, "a192_r13");

    run_start(2'b10, k256, 52, "a256");
    req_chk(4'd2, 2'd0, 1'b0, "a256_r2c0");
    chk("a256_r2c0_const", word_out, 32'h9ba35411);
    req_chk(4'd12, 2'd0, 1'b1, "a256_dec_r12");
    chk("a256_dec_const", word_out, 32'h9ba35411);
    req_chk(4'd14, 2'd3, 1'b0, "a256_r14c3");
    req_chk(4'd15, 2'd0, 1'b0, "a256_r15");

    // Illegal mode while ready leaves the schedule in service
    start = 1'b1; mode = 2'b11; key_in = k128;
    step();
    start = 1'b0;
    chk("m11_ready_kept", {31'b0, ready}, 32'd1);
    req_chk(4'd2, 2'd0, 1'b0, "m11_after");

    // Abort mid-expansion, illegal start ignored, then a clean rerun
    start = 1'b1; mode = 2'b00; key_in = k128;
    step();
    start = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_sbox", sbox_in, 32'd0);
    start = 1'b1; mode = 2'b11;
    step();
    start = 1'b0;
    repeat (60) step();
    chk("abort_m11_ready", {31'b0, ready}, 32'd0);
    chk("abort_m11_sbox", sbox_in, 32'd0);
    req = 1'b1; req_round = 4'd1;
    step();
    req = 1'b0;
    chk("abort_req_valid", {31'b0, word_valid}, 32'd0);
    chk("abort_req_err", {31'b0, req_err}, 32'd0);
    run_start(2'b00, k128, 40, "rerun");
    req_chk(4'd1, 2'd0, 1'b0, "rerun_r1c0");
    chk("rerun_const", word_out, 32'ha0fafe17);

    // Randomized keys, modes and requests
    for (int n = 0; n < 4; n++) begin
      rm = 2'($urandom_range(0, 2));
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_start(rm, rk, 4 * (int'(rm) * 2 + 11) - (4 + 2 * int'(rm)), "rnd");
      for (int q = 0; q < 20; q++)
        req_chk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd_req");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
